// File: rtl/diffusion_step_sequencer_if.sv
// Control/engine-array bundle for diffusion_step_sequencer.
// master = PS/engine side (testbench), slave = sequencer.
interface diffusion_step_sequencer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_ENG    = 4
);
   logic                  start;
   logic [DATA_WIDTH-1:0] num_steps;
   logic [NUM_ENG-1:0]    eng_en;
   logic [NUM_ENG-1:0]    finished;
   logic [NUM_ENG-1:0]    go;
   logic [DATA_WIDTH-1:0] l_step;
   logic                  buf_sel;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, num_steps, eng_en, finished,
      input  go, l_step, buf_sel, busy, done, err
   );

   modport slave (
      input  start, num_steps, eng_en, finished,
      output go, l_step, buf_sel, busy, done, err
   );
endinterface

// File: rtl/diffusion_step_sequencer.sv
// Barrier step sequencer: pulses go to all enabled engines, waits for every finished flag, repeats.
// Define STEP_TIMEOUT_EN to add a per-step WAIT watchdog that parks the sequencer in ERR.
module diffusion_step_sequencer #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_ENG        = 4,
   parameter int unsigned MAX_STEPS      = 7,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                       clk,
   input logic                       rst,
   diffusion_step_sequencer_if.slave bus
);

   localparam logic [DATA_WIDTH-1:0] LP_MAX_STEPS = DATA_WIDTH'(MAX_STEPS);

   if (NUM_ENG < 1 || MAX_STEPS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("diffusion_step_sequencer: NUM_ENG, MAX_STEPS and TIMEOUT_CYCLES must be >= 1");
   end

`ifdef STEP_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_ADVANCE, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_ADVANCE, S_DONE
   } state_t;
`endif

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_steps, w_steps_nxt;
   logic [NUM_ENG-1:0]    r_mask,  w_mask_nxt;
   logic [NUM_ENG-1:0]    r_coll,  w_coll_nxt;
   logic [NUM_ENG-1:0]    r_go,    w_go_nxt;
   logic [DATA_WIDTH-1:0] r_lstep, w_lstep_nxt;
   logic                  r_buf,   w_buf_nxt;
   logic [NUM_ENG-1:0]    w_arrived;
   logic [DATA_WIDTH-1:0] w_clamped;
   logic [DATA_WIDTH-1:0] w_lstep_inc;
   logic                  w_idle_like;

`ifdef STEP_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo, w_tmo_nxt;
`endif

   assign w_clamped   = (bus.num_steps > LP_MAX_STEPS) ? LP_MAX_STEPS : bus.num_steps;
   assign w_arrived   = r_coll | (bus.finished & r_mask);
   assign w_lstep_inc = r_lstep + DATA_WIDTH'(1);
`ifdef STEP_TIMEOUT_EN
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
`else
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_steps_nxt = r_steps;
      w_mask_nxt  = r_mask;
      w_coll_nxt  = r_coll;
      w_lstep_nxt = r_lstep;
      w_buf_nxt   = r_buf;
      if (w_idle_like) begin
         if (bus.start) begin
            w_steps_nxt = w_clamped;
            w_mask_nxt  = bus.eng_en;
            w_lstep_nxt = '0;
            w_buf_nxt   = 1'b0;
            w_state_nxt = (w_clamped == '0 || bus.eng_en == '0) ? S_DONE : S_LAUNCH;
         end
      end else begin
         case (r_state)
            S_LAUNCH: begin
               w_coll_nxt  = '0;
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               w_coll_nxt = w_arrived;
               if (w_arrived == r_mask) begin
                  w_state_nxt = S_ADVANCE;
`ifdef STEP_TIMEOUT_EN
               end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                  w_state_nxt = S_ERR;
`endif
               end
            end
            S_ADVANCE: begin
               w_lstep_nxt = w_lstep_inc;
               w_buf_nxt   = ~r_buf;
               w_state_nxt = (w_lstep_inc == r_steps) ? S_DONE : S_LAUNCH;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      // go is registered so it is high exactly during the LAUNCH cycle
      w_go_nxt = (w_state_nxt == S_LAUNCH) ? w_mask_nxt : '0;
   end

`ifdef STEP_TIMEOUT_EN
   assign w_tmo_nxt = (r_state == S_WAIT) ? r_tmo + TW'(1) : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_steps <= '0;
         r_mask  <= '0;
         r_coll  <= '0;
         r_go    <= '0;
         r_lstep <= '0;
         r_buf   <= 1'b0;
`ifdef STEP_TIMEOUT_EN
         r_tmo   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_steps <= w_steps_nxt;
         r_mask  <= w_mask_nxt;
         r_coll  <= w_coll_nxt;
         r_go    <= w_go_nxt;
         r_lstep <= w_lstep_nxt;
         r_buf   <= w_buf_nxt;
`ifdef STEP_TIMEOUT_EN
         r_tmo   <= w_tmo_nxt;
`endif
      end
   end

   assign bus.go      = r_go;
   assign bus.l_step  = r_lstep;
   assign bus.buf_sel = r_buf;
   assign bus.busy    = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_ADVANCE);
   assign bus.done    = (r_state == S_DONE);
`ifdef STEP_TIMEOUT_EN
   assign bus.err     = (r_state == S_ERR);
`else
   assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_diffusion_step_sequencer.sv
// Scoreboard bench for diffusion_step_sequencer: directed runs push expected go/done/err events,
// a negedge monitor pops and compares them as the sequencer presents them.
module tb_diffusion_step_sequencer;
   localparam int unsigned DW = 32;
   localparam int unsigned NE = 4;

   typedef enum logic [1:0] {K_GO, K_DONE, K_ERR} kind_t;
   typedef struct packed {
      kind_t          kind;
      logic [NE-1:0]  go;
      logic [DW-1:0]  lstep;
      logic           bsel;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_fail = 0;
   exp_t sb[$];
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;

   diffusion_step_sequencer_if #(.DATA_WIDTH(DW), .NUM_ENG(NE)) bus ();

   diffusion_step_sequencer #(
      .DATA_WIDTH(DW), .NUM_ENG(NE), .MAX_STEPS(7), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t  e;
      kind_t k;
      logic  hit;
      hit = 1'b0;
      k   = K_GO;
      if (!rst) begin
         if (bus.go !== '0) begin
            hit = 1'b1; k = K_GO;
         end else if (bus.done === 1'b1 && !prev_done) begin
            hit = 1'b1; k = K_DONE;
         end else if (bus.err === 1'b1 && !prev_err) begin
            hit = 1'b1; k = K_ERR;
         end
         if (hit) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_event: got kind %0d go 0x%0h l_step %0d, expected no event",
                        k, bus.go, bus.l_step);
            end else begin
               e = sb.pop_front();
               check("event_kind", 32'(k), 32'(e.kind));
               check("event_go", 32'(bus.go), 32'(e.go));
               check("event_l_step", bus.l_step, e.lstep);
               check("event_buf_sel", 32'(bus.buf_sel), 32'(e.bsel));
               check("event_busy", 32'(bus.busy), 32'(e.kind == K_GO));
            end
         end
      end
      prev_done = bus.done;
      prev_err  = bus.err;
   end

   task automatic push_ev(input kind_t k, input logic [NE-1:0] g, input int ls, input logic b);
      exp_t e;
      e.kind  = k;
      e.go    = g;
      e.lstep = DW'(ls);
      e.bsel  = b;
      sb.push_back(e);
   endtask

   task automatic start_run(input logic [DW-1:0] ns, input logic [NE-1:0] en);
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.num_steps = ns;
      bus.eng_en    = en;
      @(posedge clk); #1;
      bus.start     = 1'b0;
   endtask

   task automatic wait_go();
      int n = 0;
      while (bus.go === '0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (bus.go === '0) begin
         n_fail++;
         $display("FAIL go_wait: got no go pulse in 20 cycles, expected one");
      end
   endtask

   task automatic wait_end();
      int n = 0;
      while (bus.done !== 1'b1 && bus.err !== 1'b1 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (bus.done !== 1'b1 && bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL end_wait: got neither done nor err in 300 cycles, expected one");
      end
   endtask

   // engine i finishes 1..5 cycles into WAIT, pattern rotating per step
   task automatic do_step(input int s);
      int            d[4];
      logic [NE-1:0] fin;
      for (int i = 0; i < 4; i++) d[i] = 1 + ((2 * i + s) % 5);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         fin = '0;
         for (int i = 0; i < 4; i++) if (d[i] == c) fin[i] = 1'b1;
         bus.finished = fin;
      end
      @(posedge clk); #1;
      bus.finished = '0;
   endtask

   task automatic run(input logic [DW-1:0] ns, input logic [NE-1:0] en, input int exp_steps,
                      input logic exp_buf, input bit poke);
      for (int s = 0; s < exp_steps; s++) push_ev(K_GO, en, s, s[0]);
      push_ev(K_DONE, '0, exp_steps, exp_buf);
      start_run(ns, en);
      for (int s = 0; s < exp_steps; s++) begin
         wait_go();
         if (poke && s == 2) begin
            bus.start     = 1'b1;
            bus.num_steps = 1;
         end
         do_step(s);
      end
      wait_end();
      check("final_l_step", bus.l_step, DW'(exp_steps));
      check("final_buf_sel", 32'(bus.buf_sel), 32'(exp_buf));
      check("final_done", 32'(bus.done), 32'd1);
      check("final_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.start     = 1'b0;
      bus.num_steps = '0;
      bus.eng_en    = '0;
      bus.finished  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_go", 32'(bus.go), 32'd0);
      check("rst_l_step", bus.l_step, 32'd0);
      check("rst_buf_sel", 32'(bus.buf_sel), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);

      // zero steps: straight to DONE, no go
      push_ev(K_DONE, '0, 0, 1'b0);
      start_run(0, 4'hF);
      check("zero_steps_done", 32'(bus.done), 32'd1);
      check("zero_steps_go", 32'(bus.go), 32'd0);
      check("zero_steps_l_step", bus.l_step, 32'd0);
      // empty mask: also straight to DONE
      start_run(3, 4'h0);
      check("zero_mask_done", 32'(bus.done), 32'd1);
      check("zero_mask_busy", 32'(bus.busy), 32'd0);
      check("zero_mask_go", 32'(bus.go), 32'd0);

      run(3, 4'hF, 3, 1'b1, 1'b0);
      // clamped to 7; a start mid-run is ignored
      run(20, 4'hF, 7, 1'b1, 1'b1);

      // partial mask: disabled engines never complete the barrier
      push_ev(K_GO, 4'b0101, 0, 1'b0);
      push_ev(K_DONE, '0, 1, 1'b1);
      start_run(1, 4'b0101);
      wait_go();
      @(posedge clk); #1 bus.finished = 4'b1010;
      @(posedge clk); #1 bus.finished = '0;
      repeat (3) begin
         @(posedge clk); #1 bus.finished = 4'b1010;
      end
      @(posedge clk); #1 bus.finished = '0;
      check("mask_wait_busy", 32'(bus.busy), 32'd1);
      check("mask_wait_l_step", bus.l_step, 32'd0);
      @(posedge clk); #1 bus.finished = 4'b0101;
      @(posedge clk); #1 bus.finished = '0;
      wait_end();
      check("mask_l_step", bus.l_step, 32'd1);
      check("mask_buf_sel", 32'(bus.buf_sel), 32'd1);

      // reset during WAIT of step 2
      push_ev(K_GO, 4'hF, 0, 1'b0);
      push_ev(K_GO, 4'hF, 1, 1'b1);
      start_run(3, 4'hF);
      wait_go();
      do_step(0);
      wait_go();
      @(posedge clk); #1 bus.finished = 4'b0001;
      @(posedge clk); #1 bus.finished = '0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("midrst_go", 32'(bus.go), 32'd0);
      check("midrst_l_step", bus.l_step, 32'd0);
      check("midrst_buf_sel", 32'(bus.buf_sel), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_err", 32'(bus.err), 32'd0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("midrst_idle_busy", 32'(bus.busy), 32'd0);
      run(1, 4'hF, 1, 1'b1, 1'b0);

`ifdef STEP_TIMEOUT_EN
      // engine 3 silent: ERR after 16 WAIT cycles
      push_ev(K_GO, 4'hF, 0, 1'b0);
      push_ev(K_ERR, '0, 0, 1'b0);
      start_run(2, 4'hF);
      wait_go();
      @(posedge clk); #1 bus.finished = 4'b0111;
      @(posedge clk); #1 bus.finished = '0;
      n = 2;
      while (bus.err !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("tmo_latency", 32'(n), 32'd17);
      check("tmo_err", 32'(bus.err), 32'd1);
      check("tmo_busy", 32'(bus.busy), 32'd0);
      check("tmo_done", 32'(bus.done), 32'd0);
      check("tmo_l_step", bus.l_step, 32'd0);
      push_ev(K_GO, 4'hF, 0, 1'b0);
      push_ev(K_DONE, '0, 1, 1'b1);
      start_run(1, 4'hF);
      check("tmo_restart_err", 32'(bus.err), 32'd0);
      wait_go();
      do_step(0);
      wait_end();
      check("tmo_restart_l_step", bus.l_step, 32'd1);
`else
      n = 0;
`endif

      repeat (3) begin
         @(posedge clk); #1;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("err_tied_low_or_clear", 32'(bus.err), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
